// File: rtl/ic_fill_pkg.sv
// Shared types and packed-word field layout for the instruction-cache fill engine.
package ic_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fill_state_e;

    localparam int INS_MSB    = 38;
    localparam int INS_LSB    = 9;
    localparam int IDX_MSB    = 8;
    localparam int IDX_LSB    = 1;
    localparam int VLD_BIT    = 0;
    localparam int FILL_LEN_W = 8;

    function automatic logic [FILL_LEN_W-1:0] fill_len(input logic is_int,
                                                       input int   isa_depth,
                                                       input int   int_depth);
        return is_int ? FILL_LEN_W'(int_depth) : FILL_LEN_W'(isa_depth);
    endfunction

endpackage

// File: rtl/ic_fill_engine_if.sv
// Bus bundle between the fill engine (master) and cache / DDR / FIFO environment (slave).
interface ic_fill_engine_if #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_WIDTH      = 30,
    parameter int IC_ADDR_WIDTH  = 7
);
    logic                      miss_req;
    logic [DDR_ADDR_WIDTH-1:0] miss_addr;
    logic                      miss_is_int;
    logic                      busy;
    logic                      ins_read_req;
    logic [DDR_ADDR_WIDTH-1:0] ins_read_addr;
    logic [7:0]                ins_read_len;
    logic                      ins_reading;
    logic [ISA_WIDTH+8:0]      fifo_dout;
    logic                      fifo_empty;
    logic                      fifo_rd_en;
    logic                      cache_we;
    logic [IC_ADDR_WIDTH-1:0]  cache_waddr;
    logic [ISA_WIDTH-1:0]      cache_wdata;
    logic                      fill_done;
    logic                      seq_err;
    logic                      timeout_err;

    modport master (
        input  miss_req, miss_addr, miss_is_int, ins_reading, fifo_dout, fifo_empty,
        output busy, ins_read_req, ins_read_addr, ins_read_len, fifo_rd_en,
               cache_we, cache_waddr, cache_wdata, fill_done, seq_err, timeout_err
    );

    modport slave (
        output miss_req, miss_addr, miss_is_int, ins_reading, fifo_dout, fifo_empty,
        input  busy, ins_read_req, ins_read_addr, ins_read_len, fifo_rd_en,
               cache_we, cache_waddr, cache_wdata, fill_done, seq_err, timeout_err
    );
endinterface

// File: rtl/ic_fill_unpack.sv
// Splits a packed FIFO word into instruction, sequence index and valid flag.
module ic_fill_unpack
    import ic_fill_pkg::*;
#(
    parameter int ISA_WIDTH = 30
) (
    input  logic [ISA_WIDTH+8:0] word,
    output logic [ISA_WIDTH-1:0] ins,
    output logic [7:0]           idx,
    output logic                 valid
);
    assign ins   = word[INS_MSB:INS_LSB];
    assign idx   = word[IDX_MSB:IDX_LSB];
    assign valid = word[VLD_BIT];
endmodule

// File: rtl/ic_fill_engine.sv
// Instruction-cache refill sequencer: burst request, FIFO unpack, cache write, completion.
// Optional watchdog enabled by defining IC_FILL_TIMEOUT_EN.
module ic_fill_engine
    import ic_fill_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_WIDTH      = 30,
    parameter int ISA_DEPTH      = 72,
    parameter int INT_INS_DEPTH  = 27,
    parameter int IC_ADDR_WIDTH  = 7,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic               clk,
    input logic               rst,
    ic_fill_engine_if.master  bus
);
    if ((IC_ADDR_WIDTH > FILL_LEN_W) || ((1 << IC_ADDR_WIDTH) < ISA_DEPTH) ||
        (ISA_DEPTH > 255) || (INT_INS_DEPTH > 255) ||
        (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65536)) begin : g_bad_cfg
        $error("ic_fill_engine: inconsistent parameter set");
    end

    fill_state_e               state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      req_q, req_d;
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [FILL_LEN_W-1:0]     len_q, len_d;
    logic [FILL_LEN_W-1:0]     word_cnt_q, word_cnt_d;
    logic                      rd_pending_q, rd_pending_d;
    logic                      cache_we_q, cache_we_d;
    logic [IC_ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [ISA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                      fill_done_q, fill_done_d;
    logic                      seq_err_q, seq_err_d;
    logic                      timeout_err_q, timeout_err_d;
    logic                      fifo_rd_en;
    logic                      wr_evt;
    logic                      wd_expired;

    logic [ISA_WIDTH-1:0] ins;
    logic [7:0]           idx;
    logic                 valid;

    ic_fill_unpack #(.ISA_WIDTH(ISA_WIDTH)) u_unpack (
        .word  (bus.fifo_dout),
        .ins   (ins),
        .idx   (idx),
        .valid (valid)
    );

    // A popped word is presented one cycle after its pop; invalid words are skipped.
    assign wr_evt = (state_q == ST_FILL) && rd_pending_q && valid;

`ifdef IC_FILL_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        wd_active, wd_progress;

    always_comb begin
        wd_active   = (state_q == ST_REQ) || (state_q == ST_FILL);
        wd_progress = ((state_q == ST_REQ) && bus.ins_reading) || wr_evt;
        wd_expired  = wd_active && !wd_progress && (wd_q == 16'(TIMEOUT_CYCLES - 1));
        wd_d        = 16'd0;
        if (wd_active && !wd_progress) begin
            wd_d = wd_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wd_q <= 16'd0;
        else     wd_q <= wd_d;
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            word_cnt_q    <= '0;
            rd_pending_q  <= 1'b0;
            cache_we_q    <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            fill_done_q   <= 1'b0;
            seq_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            word_cnt_q    <= word_cnt_d;
            rd_pending_q  <= rd_pending_d;
            cache_we_q    <= cache_we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            fill_done_q   <= fill_done_d;
            seq_err_q     <= seq_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.miss_req)            state_d = ST_REQ;
            ST_REQ:  if (bus.ins_reading)         state_d = ST_FILL;
            ST_FILL: if (word_cnt_q == len_q)     state_d = ST_DONE;
            default:                              state_d = ST_IDLE;
        endcase
        if (wd_expired) state_d = ST_DONE;
    end

    // Pops in IDLE discard stale data; in FILL the in-flight word is counted so no over-read.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rst && !bus.fifo_empty) begin
            case (state_q)
                ST_IDLE: fifo_rd_en = 1'b1;
                ST_FILL: fifo_rd_en = ({1'b0, word_cnt_q} + {8'd0, rd_pending_q}) < {1'b0, len_q};
                default: fifo_rd_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        req_d         = (state_d == ST_REQ);
        fill_done_d   = (state_d == ST_DONE);
        rd_pending_d  = fifo_rd_en;
        addr_d        = addr_q;
        len_d         = len_q;
        word_cnt_d    = word_cnt_q;
        cache_we_d    = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        seq_err_d     = seq_err_q;
        timeout_err_d = timeout_err_q | wd_expired;

        if ((state_q == ST_IDLE) && bus.miss_req) begin
            addr_d     = bus.miss_addr;
            len_d      = fill_len(bus.miss_is_int, ISA_DEPTH, INT_INS_DEPTH);
            word_cnt_d = '0;
        end

        // The write slot comes from word_cnt even when the carried index disagrees.
        if (wr_evt) begin
            cache_we_d = 1'b1;
            waddr_d    = word_cnt_q[IC_ADDR_WIDTH-1:0];
            wdata_d    = ins;
            word_cnt_d = word_cnt_q + 8'd1;
            if (idx != word_cnt_q) seq_err_d = 1'b1;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.ins_read_req  = req_q;
    assign bus.ins_read_addr = addr_q;
    assign bus.ins_read_len  = len_q;
    assign bus.fifo_rd_en    = fifo_rd_en;
    assign bus.cache_we      = cache_we_q;
    assign bus.cache_waddr   = waddr_q;
    assign bus.cache_wdata   = wdata_q;
    assign bus.fill_done     = fill_done_q;
    assign bus.seq_err       = seq_err_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_ic_fill_engine.sv
// Directed self-checking bench for ic_fill_engine with a behavioural standard-mode FIFO.
module tb_ic_fill_engine;
    localparam int DAW = 28;
    localparam int IW  = 30;
    localparam int IAW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ic_fill_engine_if #(.DDR_ADDR_WIDTH(DAW), .ISA_WIDTH(IW), .IC_ADDR_WIDTH(IAW)) bus ();

    ic_fill_engine #(
        .DDR_ADDR_WIDTH(DAW), .ISA_WIDTH(IW), .ISA_DEPTH(72), .INT_INS_DEPTH(27),
        .IC_ADDR_WIDTH(IAW), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [38:0] mem [0:2047];
    int          wr_ptr  = 0;
    int          rd_ptr  = 0;
    int          pop_cnt = 0;
    logic        stall    = 1'b0;
    logic        stall_en = 1'b0;
    logic [38:0] dout_r   = '0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr) || stall;
    assign bus.fifo_dout  = dout_r;

    always @(posedge clk) begin
        stall <= stall_en ? ~stall : 1'b0;
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            dout_r  <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    function automatic logic [29:0] pat(input logic [5:0] s, input int i);
        return {s, i[15:0], 8'h5C};
    endfunction

    task automatic push_word(input logic [29:0] ins, input logic [7:0] idx, input logic v);
        mem[wr_ptr] = {ins, idx, v};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_seq(input logic [5:0] s, input int n);
        for (int i = 0; i < n; i++) push_word(pat(s, i), 8'(i), 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_miss(input logic [27:0] a, input logic is_int);
        @(negedge clk);
        bus.miss_addr   = a;
        bus.miss_is_int = is_int;
        bus.miss_req    = 1'b1;
        @(negedge clk);
        bus.miss_req    = 1'b0;
    endtask

    // Observes writes until busy falls after fill_done; outputs stay -1 if never seen.
    task automatic collect(input int max_cyc, input logic [5:0] s,
                           output int nwr, output int nbad, output int ndone,
                           output int first_we, output int last_we,
                           output int done_c, output int low_c, output int left);
        nwr = 0; nbad = 0; ndone = 0;
        first_we = -1; last_we = -1; done_c = -1; low_c = -1; left = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (bus.cache_we) begin
                if (nwr == 0) first_we = c;
                if (bus.cache_waddr !== 7'(nwr) || bus.cache_wdata !== pat(s, nwr)) nbad++;
                nwr++;
                last_we = c;
            end
            if (bus.fill_done) begin
                ndone++;
                done_c = c;
                left   = wr_ptr - rd_ptr;
            end
            if (ndone > 0 && !bus.busy) begin
                low_c = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.ins_read_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.ins_read_req); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b exp 0", bus.fifo_rd_en); end
        checks++; if (bus.cache_we !== 1'b0 || bus.fill_done !== 1'b0) begin errors++; $display("FAIL rst_we_done got %b%b exp 00", bus.cache_we, bus.fill_done); end
        checks++; if (bus.seq_err !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_errs got %b%b exp 00", bus.seq_err, bus.timeout_err); end
        checks++; if (bus.ins_read_addr !== 28'd0 || bus.ins_read_len !== 8'd0) begin errors++; $display("FAIL rst_addr_len got %h/%0d exp 0/0", bus.ins_read_addr, bus.ins_read_len); end
        checks++; if (bus.cache_waddr !== 7'd0 || bus.cache_wdata !== 30'd0) begin errors++; $display("FAIL rst_wr got %h/%h exp 0/0", bus.cache_waddr, bus.cache_wdata); end
        $display("reset: state checked");
    endtask

    task automatic test_normal();
        int nwr, nbad, ndone, fw, lw, dc, lc, left;
        repeat (4) @(negedge clk);
        start_miss(28'h100, 1'b0);
        checks++; if (bus.ins_read_req !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL normal_req got %b%b exp 11", bus.ins_read_req, bus.busy); end
        checks++; if (bus.ins_read_addr !== 28'h100) begin errors++; $display("FAIL normal_addr got %h exp 100", bus.ins_read_addr); end
        checks++; if (bus.ins_read_len !== 8'd72) begin errors++; $display("FAIL normal_len got %0d exp 72", bus.ins_read_len); end
        repeat (3) @(negedge clk);
        checks++; if (bus.ins_read_req !== 1'b1) begin errors++; $display("FAIL normal_req_hold got %b exp 1", bus.ins_read_req); end
        bus.ins_reading = 1'b1;
        push_seq(6'h11, 74);
        @(negedge clk);
        bus.ins_reading = 1'b0;
        checks++; if (bus.ins_read_req !== 1'b0) begin errors++; $display("FAIL normal_req_drop got %b exp 0", bus.ins_read_req); end
        collect(400, 6'h11, nwr, nbad, ndone, fw, lw, dc, lc, left);
        checks++; if (nwr !== 72 || nbad !== 0) begin errors++; $display("FAIL normal_writes got %0d bad %0d exp 72 bad 0", nwr, nbad); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL normal_done_cnt got %0d exp 1", ndone); end
        checks++; if (lw - fw !== 71) begin errors++; $display("FAIL normal_throughput got span %0d exp 71", lw - fw); end
        checks++; if (dc !== lw + 1 || lc !== dc + 1) begin errors++; $display("FAIL normal_done_lat got done %0d low %0d exp %0d %0d", dc, lc, lw + 1, lw + 2); end
        checks++; if (left !== 2) begin errors++; $display("FAIL normal_overread got left %0d exp 2", left); end
        checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL normal_seq got %b exp 0", bus.seq_err); end
        repeat (4) @(negedge clk);
        checks++; if (rd_ptr !== wr_ptr) begin errors++; $display("FAIL normal_drain got left %0d exp 0", wr_ptr - rd_ptr); end
        $display("normal: writes=%0d done_cyc=%0d", nwr, dc);
    endtask

    task automatic test_interrupt(input logic [5:0] s);
        int nwr, nbad, ndone, fw, lw, dc, lc, left;
        repeat (4) @(negedge clk);
        start_miss(28'hABCDEF, 1'b1);
        checks++; if (bus.ins_read_len !== 8'd27 || bus.ins_read_addr !== 28'hABCDEF) begin errors++; $display("FAIL int_len_addr got %0d/%h exp 27/abcdef", bus.ins_read_len, bus.ins_read_addr); end
        bus.ins_reading = 1'b1;
        @(negedge clk);
        bus.ins_reading = 1'b0;
        bus.miss_addr   = 28'hFFF;
        bus.miss_is_int = 1'b0;
        bus.miss_req    = 1'b1;
        @(negedge clk);
        bus.miss_req    = 1'b0;
        @(negedge clk);
        checks++; if (bus.ins_read_addr !== 28'hABCDEF || bus.ins_read_len !== 8'd27 || bus.ins_read_req !== 1'b0) begin errors++; $display("FAIL int_busy_miss got %h/%0d req %b exp abcdef/27 req 0", bus.ins_read_addr, bus.ins_read_len, bus.ins_read_req); end
        push_seq(s, 27);
        collect(200, s, nwr, nbad, ndone, fw, lw, dc, lc, left);
        checks++; if (nwr !== 27 || nbad !== 0) begin errors++; $display("FAIL int_writes got %0d bad %0d exp 27 bad 0", nwr, nbad); end
        checks++; if (ndone !== 1 || dc !== lw + 1) begin errors++; $display("FAIL int_done got cnt %0d cyc %0d exp 1 %0d", ndone, dc, lw + 1); end
        checks++; if (left !== 0) begin errors++; $display("FAIL int_left got %0d exp 0", left); end
        $display("interrupt: writes=%0d done_cyc=%0d", nwr, dc);
    endtask

    task automatic test_stalls();
        int nwr, nbad, ndone, fw, lw, dc, lc, left;
        repeat (4) @(negedge clk);
        start_miss(28'h340, 1'b0);
        stall_en = 1'b1;
        bus.ins_reading = 1'b1;
        for (int i = 0; i < 5; i++) push_word(pat(6'h21, i), 8'(i), 1'b1);
        push_word(30'h3FFF_FFFF, 8'd5, 1'b0);
        for (int i = 5; i < 72; i++) push_word(pat(6'h21, i), 8'(i), 1'b1);
        @(negedge clk);
        bus.ins_reading = 1'b0;
        collect(600, 6'h21, nwr, nbad, ndone, fw, lw, dc, lc, left);
        stall_en = 1'b0;
        checks++; if (nwr !== 72 || nbad !== 0) begin errors++; $display("FAIL stall_writes got %0d bad %0d exp 72 bad 0", nwr, nbad); end
        checks++; if (ndone !== 1 || left !== 0) begin errors++; $display("FAIL stall_done got cnt %0d left %0d exp 1 0", ndone, left); end
        checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL stall_seq got %b exp 0", bus.seq_err); end
        $display("stalls: writes=%0d span=%0d", nwr, lw - fw);
    endtask

    task automatic test_seq_err();
        int nwr, nbad, ndone, fw, lw, dc, lc, left;
        repeat (4) @(negedge clk);
        start_miss(28'h500, 1'b0);
        bus.ins_reading = 1'b1;
        for (int i = 0; i < 72; i++) push_word(pat(6'h2B, i), (i == 10) ? 8'd11 : 8'(i), 1'b1);
        @(negedge clk);
        bus.ins_reading = 1'b0;
        collect(400, 6'h2B, nwr, nbad, ndone, fw, lw, dc, lc, left);
        checks++; if (nwr !== 72 || nbad !== 0) begin errors++; $display("FAIL seq_writes got %0d bad %0d exp 72 bad 0", nwr, nbad); end
        checks++; if (bus.seq_err !== 1'b1) begin errors++; $display("FAIL seq_set got %b exp 1", bus.seq_err); end
        test_interrupt(6'h2C);
        checks++; if (bus.seq_err !== 1'b1) begin errors++; $display("FAIL seq_sticky got %b exp 1", bus.seq_err); end
        apply_reset();
        checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL seq_clear got %b exp 0", bus.seq_err); end
        $display("seq_err: set, held, cleared by rst");
    endtask

    task automatic test_reset_drain();
        int nwr, nwe, p0;
        repeat (4) @(negedge clk);
        start_miss(28'h200, 1'b0);
        bus.ins_reading = 1'b1;
        push_seq(6'h3A, 72);
        @(negedge clk);
        bus.ins_reading = 1'b0;
        nwr = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.cache_we) nwr++;
            if (nwr == 30) break;
        end
        checks++; if (nwr !== 30) begin errors++; $display("FAIL drain_reach30 got %0d exp 30", nwr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.cache_we !== 1'b0 || bus.ins_read_req !== 1'b0) begin errors++; $display("FAIL drain_rst_out got busy %b we %b req %b exp 000", bus.busy, bus.cache_we, bus.ins_read_req); end
        checks++; if (bus.cache_waddr !== 7'd0 || bus.ins_read_len !== 8'd0 || bus.ins_read_addr !== 28'd0) begin errors++; $display("FAIL drain_rst_regs got %h/%0d/%h exp 0/0/0", bus.cache_waddr, bus.ins_read_len, bus.ins_read_addr); end
        nwe = 0;
        repeat (100) begin @(negedge clk); if (bus.cache_we) nwe++; end
        checks++; if (nwe !== 0 || rd_ptr !== wr_ptr) begin errors++; $display("FAIL drain_residual got we %0d left %0d exp 0 0", nwe, wr_ptr - rd_ptr); end
        p0 = pop_cnt;
        for (int i = 0; i < 5; i++) push_word(pat(6'h3B, i), 8'(i), 1'b1);
        repeat (20) begin @(negedge clk); if (bus.cache_we) nwe++; end
        checks++; if (pop_cnt - p0 !== 5 || nwe !== 0) begin errors++; $display("FAIL drain_stale got pops %0d we %0d exp 5 0", pop_cnt - p0, nwe); end
        test_interrupt(6'h3C);
        checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL drain_refill_seq got %b exp 0", bus.seq_err); end
        $display("reset_drain: stale pops=%0d", pop_cnt - p0);
    endtask

    task automatic test_timeout();
`ifdef IC_FILL_TIMEOUT_EN
        int found;
        found = -1;
        repeat (4) @(negedge clk);
        start_miss(28'h700, 1'b0);
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (bus.fill_done && found < 0) begin
                found = c;
                checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", bus.timeout_err); end
            end
            if (found >= 0 && !bus.busy) break;
        end
        checks++; if (found !== 64) begin errors++; $display("FAIL to_cycle got %0d exp 64", found); end
        checks++; if (bus.busy !== 1'b0 || bus.ins_read_req !== 1'b0) begin errors++; $display("FAIL to_idle got busy %b req %b exp 00", bus.busy, bus.ins_read_req); end
        apply_reset();
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", bus.timeout_err); end
        $display("timeout: fill_done at cycle %0d", found);
`else
        repeat (4) @(negedge clk);
        start_miss(28'h700, 1'b0);
        repeat (100) @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.ins_read_req !== 1'b1) begin errors++; $display("FAIL to_wait got busy %b req %b exp 11", bus.busy, bus.ins_read_req); end
        checks++; if (bus.timeout_err !== 1'b0 || bus.fill_done !== 1'b0) begin errors++; $display("FAIL to_flag_off got %b%b exp 00", bus.timeout_err, bus.fill_done); end
        apply_reset();
        $display("timeout: watchdog absent, request held");
`endif
    endtask

    initial begin
        bus.miss_req    = 1'b0;
        bus.miss_addr   = '0;
        bus.miss_is_int = 1'b0;
        bus.ins_reading = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_normal();
        test_interrupt(6'h22);
        checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL int_seq got %b exp 0", bus.seq_err); end
        test_stalls();
        test_seq_err();
        test_reset_drain();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench time limit reached");
    end
endmodule
